// File: rtl/spi_rx_fifo_if.sv
// Bus bundle for the SPI receive FIFO: serial framing inputs, the local
// drain handshake, FIFO status and the sticky error flags.
interface spi_rx_fifo_if #(
   parameter int ADDR_W = 2
);
   logic              CS;
   logic              MOSI;
   logic              rd_en;
   logic              err_clr;
   logic [7:0]        rd_data;
   logic              rd_valid;
   logic              empty;
   logic              full;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic              frame_error;

   // Side that drives the serial line and drains the FIFO.
   modport master (
      output CS, MOSI, rd_en, err_clr,
      input  rd_data, rd_valid, empty, full, count, overflow, frame_error
   );

   // The receive stage itself.
   modport slave (
      input  CS, MOSI, rd_en, err_clr,
      output rd_data, rd_valid, empty, full, count, overflow, frame_error
   );
endinterface

// File: rtl/spi_rx_fifo.sv
// SPI slave receive stage. Deserialises MOSI (LSB first) into bytes while CS
// is low, queues complete bytes in a DEPTH-entry circular FIFO and exposes a
// read-strobe drain port. Sticky flags report dropped bytes (overflow) and CS
// rising with a partial byte pending (frame_error). Everything runs on SCLK.
module spi_rx_fifo #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic             SCLK,
   input  logic             reset,
   spi_rx_fifo_if.slave     bus
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

   // ---------------------------------------------------------------------
   // State registers and their next-state values
   // ---------------------------------------------------------------------
   logic [2:0]        bit_cnt_q,     bit_cnt_d;
   logic [6:0]        shreg_q,       shreg_d;
   logic [7:0]        mem_q [DEPTH],  mem_d [DEPTH];
   logic [ADDR_W-1:0] rd_ptr_q,      rd_ptr_d;
   logic [ADDR_W-1:0] wr_ptr_q,      wr_ptr_d;
   logic [ADDR_W:0]   count_q,       count_d;
   logic              empty_q,       empty_d;
   logic              full_q,        full_d;
   logic [7:0]        rd_data_q,     rd_data_d;
   logic              rd_valid_q,    rd_valid_d;
   logic              overflow_q,    overflow_d;
   logic              frame_error_q, frame_error_d;

   // Per-cycle event strobes
   logic              byte_done_s;
   logic              frame_set_s;
   logic [7:0]        byte_s;
   logic              pop_s;
   logic              push_s;
   logic              drop_s;

   // Deserialiser: shift in one bit per edge while selected, flag the 8th bit,
   // and abandon any partial byte (flagging it) when CS is seen high.
   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      byte_done_s = 1'b0;
      frame_set_s = 1'b0;
      if (!bus.CS) begin
         if (bit_cnt_q == 3'd7) begin
            byte_done_s = 1'b1;
         end else begin
            for (int i = 0; i < 7; i++) begin
               if (bit_cnt_q == 3'(i)) begin
                  shreg_d[i] = bus.MOSI;
               end else begin
                  shreg_d[i] = shreg_q[i];
               end
            end
         end
         bit_cnt_d = bit_cnt_q + 3'd1;
      end else begin
         if (bit_cnt_q != 3'd0) begin
            frame_set_s = 1'b1;
         end else begin
            frame_set_s = 1'b0;
         end
         bit_cnt_d = 3'd0;
      end
      // The 8th bit is taken straight from the line so the byte lands this edge.
      byte_s = {bus.MOSI, shreg_q};
   end

   // FIFO control: a pop only happens when non-empty; a finished byte enters
   // unless the FIFO is full with no pop freeing a slot in the same cycle.
   always_comb begin
      pop_s  = bus.rd_en && !empty_q;
      push_s = byte_done_s && (!full_q || pop_s);
      drop_s = byte_done_s && full_q && !pop_s;

      mem_d = mem_q;
      if (push_s) begin
         mem_d[wr_ptr_q] = byte_s;
         wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
      end else begin
         wr_ptr_d        = wr_ptr_q;
      end

      // Read data is taken from the pre-edge memory, so a full-FIFO
      // push/pop on the same slot still returns the older byte.
      if (pop_s) begin
         rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
         rd_data_d  = mem_q[rd_ptr_q];
         rd_valid_d = 1'b1;
      end else begin
         rd_ptr_d   = rd_ptr_q;
         rd_data_d  = rd_data_q;
         rd_valid_d = 1'b0;
      end

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
         2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
         default: count_d = count_q;
      endcase

      // Status flags are registered alongside count so they track it exactly.
      empty_d = (count_d == (ADDR_W + 1)'(0));
      full_d  = (count_d == DEPTH_C);
   end

   // Sticky error flags: a set condition outranks a simultaneous clear.
   always_comb begin
      if (drop_s) begin
         overflow_d = 1'b1;
      end else if (bus.err_clr) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end

      if (frame_set_s) begin
         frame_error_d = 1'b1;
      end else if (bus.err_clr) begin
         frame_error_d = 1'b0;
      end else begin
         frame_error_d = frame_error_q;
      end
   end

   // State update; reset outranks every other input and drops any partial byte.
   always_ff @(posedge SCLK) begin
      if (reset) begin
         bit_cnt_q     <= 3'd0;
         shreg_q       <= 7'd0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         empty_q       <= 1'b1;
         full_q        <= 1'b0;
         rd_data_q     <= 8'h00;
         rd_valid_q    <= 1'b0;
         overflow_q    <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         bit_cnt_q     <= bit_cnt_d;
         shreg_q       <= shreg_d;
         mem_q         <= mem_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         empty_q       <= empty_d;
         full_q        <= full_d;
         rd_data_q     <= rd_data_d;
         rd_valid_q    <= rd_valid_d;
         overflow_q    <= overflow_d;
         frame_error_q <= frame_error_d;
      end
   end

   assign bus.rd_data     = rd_data_q;
   assign bus.rd_valid    = rd_valid_q;
   assign bus.empty       = empty_q;
   assign bus.full        = full_q;
   assign bus.count       = count_q;
   assign bus.overflow    = overflow_q;
   assign bus.frame_error = frame_error_q;

endmodule
